// File: rtl/ro_puf_pkg.sv
// Shared definitions for the ring-oscillator PUF scan logic: bank size,
// select width, scan FSM states and the one-hot enable decode.
package ro_puf_pkg;

  localparam int NUM_RO = 16;
  localparam int SEL_W  = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE_A = 3'd1,
    MEAS_A   = 3'd2,
    SETTLE_B = 3'd3,
    MEAS_B   = 3'd4,
    DONE     = 3'd5
  } scan_state_t;

  // Turn an RO index into the enable pattern for the bank
  function automatic logic [NUM_RO-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_RO-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Brings the asynchronous RO mux output into the clock domain, detects its
// rising edges and counts them with saturation. The count output already
// includes an edge being accepted in the current cycle, so a reader that
// samples it on the last cycle of a window gets the complete total.
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             ro_sample,
  output logic [CNT_W-1:0] count
);

  logic             sync1;
  logic             sync2;
  logic             prev;
  logic             rise;
  logic [CNT_W-1:0] count_q;

  // Two-flop synchronizer followed by a history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= ro_sample;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

  // Next count: one more on an enabled edge, pinned at all-ones once full
  always_comb begin
    count = count_q;
    if (enable && rise && (count_q != {CNT_W{1'b1}})) begin
      count = count_q + CNT_W'(1);
    end
  end

  // Counter register, cleared by reset or by the settle phase
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else begin
      count_q <= count;
    end
  end

endmodule

// File: rtl/ro_scan_controller.sv
// Evaluates one RO-PUF challenge: runs RO A, counts its edges over a fixed
// window, repeats for RO B, then publishes both counts and the response bit.
module ro_scan_controller
  import ro_puf_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int WIN_CYCLES    = 1024,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ch_a,
  input  logic [3:0]       ch_b,
  output logic [15:0]      ro_en,
  output logic [3:0]       select,
  input  logic             ro_sample,
  output logic             busy,
  output logic             done,
  output logic             resp,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
);

  localparam int TMR_MAX = (SETTLE_CYCLES > WIN_CYCLES) ? SETTLE_CYCLES : WIN_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_CYCLES - 1);

  scan_state_t      state;
  logic [TMR_W-1:0] timer;
  logic [SEL_W-1:0] lat_a;
  logic [SEL_W-1:0] lat_b;
  logic [CNT_W-1:0] hold_a;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clear;
  logic             cnt_en;

  // The counter is held at zero while an RO settles and counts only in a window
  assign cnt_clear = (state == SETTLE_A) || (state == SETTLE_B);
  assign cnt_en    = (state == MEAS_A) || (state == MEAS_B);

  ro_edge_counter #(
    .CNT_W(CNT_W)
  ) u_edge_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .ro_sample(ro_sample),
    .count    (cnt)
  );

  // Scan sequencer; every output is registered and set on the state transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      lat_a   <= '0;
      lat_b   <= '0;
      hold_a  <= '0;
      ro_en   <= '0;
      select  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      resp    <= 1'b0;
      count_a <= '0;
      count_b <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lat_a  <= ch_a;
            lat_b  <= ch_b;
            ro_en  <= onehot(ch_a);
            select <= ch_a;
            busy   <= 1'b1;
            timer  <= '0;
            state  <= SETTLE_A;
          end
        end
        SETTLE_A: begin
          if (timer == SETTLE_LAST) begin
            timer <= '0;
            state <= MEAS_A;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        MEAS_A: begin
          if (timer == WIN_LAST) begin
            hold_a <= cnt;
            ro_en  <= onehot(lat_b);
            select <= lat_b;
            timer  <= '0;
            state  <= SETTLE_B;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        SETTLE_B: begin
          if (timer == SETTLE_LAST) begin
            timer <= '0;
            state <= MEAS_B;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        MEAS_B: begin
          if (timer == WIN_LAST) begin
            count_a <= hold_a;
            count_b <= cnt;
            resp    <= (hold_a > cnt);
            ro_en   <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            timer   <= '0;
            state   <= DONE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ro_en <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ro_scan_controller.md
RO_SCAN_CONTROLLER -- requirements
Module: ro_scan_controller

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16: cycles the selected RO pair runs before each count window; legal minimum 3.
REQ-002 Parameter WIN_CYCLES, default 1024: length in cycles of each edge-count window.
REQ-003 Parameter CNT_W, default 16: width of each edge counter.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  request to evaluate one challenge; sampled only in IDLE.
REQ-007 ch_a  in  4  index of the first RO of the challenge pair.
REQ-008 ch_b  in  4  index of the second RO of the challenge pair.
REQ-009 ro_en  out  16  one-hot enable to the 16-RO bank.
REQ-010 select  out  4  select code driven to the 16:1 RO mux.
REQ-011 ro_sample  in  1  asynchronous output of the 16:1 RO mux.
REQ-012 busy  out  1  high from start acceptance until done.
REQ-013 done  out  1  single-cycle pulse when the result is valid.
REQ-014 resp  out  1  PUF response bit: 1 when count_a > count_b, else 0.
REQ-015 count_a / count_b  out  CNT_W each  edge counts for RO A and RO B; held until the next done.

Function
REQ-016 FSM states: IDLE, SETTLE_A, MEAS_A, SETTLE_B, MEAS_B, DONE.
REQ-017 IDLE -> SETTLE_A when start=1; ch_a and ch_b are latched in that same cycle, and later input changes are ignored.
REQ-018 Residency: SETTLE_x lasts exactly SETTLE_CYCLES cycles; MEAS_x lasts exactly WIN_CYCLES cycles; DONE lasts 1 cycle and returns to IDLE.
REQ-019 Latency: if start is accepted in cycle 0, done=1 in cycle 2*(SETTLE_CYCLES+WIN_CYCLES)+1.
REQ-020 In SETTLE_A and MEAS_A: select=latched ch_a and ro_en=onehot(ch_a). In SETTLE_B and MEAS_B: select=latched ch_b and ro_en=onehot(ch_b). In IDLE and DONE: ro_en=0 and select holds its last value.
REQ-021 ro_sample passes through a 2-flop synchronizer and a rising-edge detector; an edge is counted only while the FSM is in MEAS_x.
REQ-022 The counter clears on entry to each SETTLE_x; counters saturate at 2^CNT_W-1 and do not wrap.
REQ-023 count_a, count_b and resp update only in the DONE cycle; otherwise they hold their values.
REQ-024 Equal counts, including ch_a==ch_b, give resp=0; the scan still runs in full.
REQ-025 start while busy=1 is ignored and neither queued nor flagged.
REQ-026 busy=1 in every non-IDLE state except DONE; done and busy are never both 1.

Reset
REQ-027 rst=1 at any clock edge forces IDLE with ro_en=0, select=0, busy=0, done=0, resp=0, count_a=0, count_b=0, and clears the synchronizer and edge-counter state; a scan in progress is aborted with no done.
REQ-028 start sampled during the rst=1 cycle is discarded.

Structure
REQ-029 Shared package ro_puf_pkg holds: NUM_RO=16, SEL_W=4, the FSM state enum, and a onehot decode function.
REQ-030 One sub-module, ro_edge_counter, contains the synchronizer, edge detector, and saturating counter (clear, enable, count ports); the FSM, latches and result registers live in the top level.

Verification
(All scenarios use SETTLE_CYCLES=4 and WIN_CYCLES=100 unless stated.)
REQ-031 Reset: hold rst for 3 cycles -> all outputs 0, FSM in IDLE; pulse start during rst -> no scan starts.
REQ-032 ch_a=3, ch_b=7, start at cycle 0. The model drives ro_sample with period 4 when select=3 and period 10 when select=7.
  -> ro_en=0x0008 during A, then 0x0080 during B.
  -> count_a=25, count_b=10, resp=1.
  -> done in cycle 209 only; busy high in cycles 1-208.
REQ-033 ch_a=ch_b=5 with identical stimulus -> count_a=count_b, resp=0, done in cycle 209.
REQ-034 Pulse start with ch_a=1 at cycle 50 of an active scan -> ignored; latched challenge and results unchanged.
REQ-035 Assert rst in MEAS_A, then start a new scan -> the aborted scan gives no done; ro_en=0 after the reset edge; the new scan completes normally.
REQ-036 CNT_W=4, ro_sample toggling every cycle (50 edges per window) -> count_a=count_b=15 (saturated), resp=0.
